// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - FSM state encoding (idle / waiting on memory / halted)
//   - Queue depth and matching counter width
//   - PC step and default reset PC
package fetch_unit_pkg;

  // Instructions are 16-bit, so the byte-addressed PC advances by 2.
  localparam int PC_STEP = 2;

  // Depth of the instruction queue between memory and decode.
  localparam int QDEPTH  = 2;
  localparam int PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  // Wide enough to hold QDEPTH + 1 (queue count plus one outstanding read).
  localparam int CNT_W   = $clog2(QDEPTH + 2);

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // no read outstanding
    S_WAIT   = 2'd1,  // one read outstanding, mem_req held high
    S_HALTED = 2'd2   // HLT retired, fetch stopped until reset
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_queue.sv
// Small FIFO of fetched {instruction, pc} pairs between memory and decode.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_push, i_push_*   write one entry (ignored when full unless popping)
//   i_pop              remove head entry (ignored when empty)
//   i_flush            drop all entries; wins over push/pop
//   o_count            number of valid entries
//   o_head_data/pc     oldest entry (stale when o_count == 0)
module fetch_unit_queue
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic [ADDR_W-1:0] i_push_pc,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_head_data,
  output logic [ADDR_W-1:0] o_head_pc
);

  logic [DATA_W-1:0] r_data [QDEPTH];
  logic [ADDR_W-1:0] r_pc   [QDEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != '0);
  // A full queue can still accept a push when the head leaves the same cycle.
  assign w_do_push = i_push && ((r_count < CNT_W'(QDEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // The fetch FSM's room rule never pushes into a full queue.
      assert (!(i_push && !w_do_pop && (r_count == CNT_W'(QDEPTH))));
      if (w_do_push) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_pc[r_wr_ptr]   <= i_push_pc;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_count     = r_count;
  assign o_head_data = r_data[r_rd_ptr];
  assign o_head_pc   = r_pc[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time to a
// multi-cycle instruction memory, buffers returned words and presents them
// to decode with valid/ready.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_req/mem_addr            read request, held with stable address until mem_valid
//   mem_valid/mem_data          one-cycle return of the outstanding read
//   inst_valid/inst_ready       decode handshake; inst, inst_pc, inst_pcs = head, pc, pc+2
//   redirect/redirect_pc        taken branch: flush and refetch from target (bit 0 forced 0)
//   halt                        presented instruction is HLT (meaningful only on handshake)
//   hlt                         fetch halted, sticky until reset
//   dbg_state                   current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; mem_req/mem_addr stay stable until that edge; redirect
// overrides inst_ready in the cycle it is asserted.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] inst_pcs,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              hlt,
  output logic [1:0]        dbg_state
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_drop;

  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_head_pc;
  logic              w_inst_valid;
  logic              w_handshake;
  logic              w_redirect_take;
  logic              w_halt_take;
  logic              w_ret;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_outstanding;
  logic              w_room;
  logic              w_issue;
  logic [ADDR_W-1:0] w_redirect_target;

  assign w_inst_valid    = (w_count != '0) && (r_state != S_HALTED);
  assign w_handshake     = w_inst_valid && inst_ready;
  // Once halted only reset restarts fetch, so redirects are ignored there.
  assign w_redirect_take = redirect && (r_state != S_HALTED);
  assign w_halt_take     = halt && w_handshake && !w_redirect_take;
  assign w_ret           = (r_state == S_WAIT) && mem_valid;
  assign w_push          = w_ret && !r_drop && !w_redirect_take && !w_halt_take;
  assign w_pop           = w_handshake && !w_redirect_take;
  assign w_flush         = w_redirect_take || w_halt_take;
  assign w_outstanding   = (r_state == S_WAIT);
  // Queue entries plus the in-flight read may never exceed the queue depth.
  assign w_room          = (w_count + CNT_W'(w_outstanding)) < CNT_W'(QDEPTH);
  assign w_issue         = (r_state == S_IDLE) && (w_state_next == S_WAIT);
  assign w_redirect_target = redirect_pc & ~ADDR_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_halt_take) begin
          w_state_next = S_HALTED;
        end else if (!w_redirect_take && w_room) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_halt_take) begin
          w_state_next = S_HALTED;
        end else if (mem_valid) begin
          w_state_next = S_IDLE;
        end
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    mem_req   = (r_state == S_WAIT);
    hlt       = (r_state == S_HALTED);
    dbg_state = r_state;
  end

  // PC, request address and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_drop     <= 1'b0;
    end else begin
      if (w_redirect_take) begin
        r_fetch_pc <= w_redirect_target;
      end else if (w_ret && !r_drop) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(PC_STEP);
      end

      if (w_issue) begin
        r_mem_addr <= r_fetch_pc;
      end

      // A redirect while a read is in flight marks that read as stale; the
      // address on the bus is left alone until the memory answers.
      if (r_state != S_WAIT || w_ret) begin
        r_drop <= 1'b0;
      end else if (w_redirect_take) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign mem_addr = r_mem_addr;

  fetch_unit_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (mem_data),
    .i_push_pc   (r_mem_addr),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_head_data (w_head_data),
    .o_head_pc   (w_head_pc)
  );

  // Outputs read as zero when nothing is presented.
  assign inst_valid = w_inst_valid;
  assign inst       = w_inst_valid ? w_head_data : '0;
  assign inst_pc    = w_inst_valid ? w_head_pc : '0;
  assign inst_pcs   = w_inst_valid ? (w_head_pc + ADDR_W'(PC_STEP)) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pcs;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        hlt;
  logic [1:0]  dbg_state;

  fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_valid   (mem_valid),
    .mem_data    (mem_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pcs    (inst_pcs),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .hlt         (hlt),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];        // directed expected inst_pc sequence
  logic [15:0] exp_pc;          // next instruction address decode should see
  logic [15:0] exp_req_pc;      // next address the fetcher should request
  logic [15:0] req_addr;        // address of the read the memory is serving
  bit          busy;            // memory is serving a read
  int          cnt;             // cycles left before the memory answers
  int          lat_fixed;       // 0 = random latency 1..4
  bit          exp_halted;
  bit          expect_empty;    // a flush happened: nothing presented next cycle

  // Program memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'hB3C1) + {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Move to the next falling edge, check per-cycle rules, drive the memory.
  task automatic sample();
    @(negedge clk);
    mem_valid = 1'b0;
    if (expect_empty) begin
      chk("flush_empty", inst_valid, 1'b0);
      expect_empty = 1'b0;
    end
    if (exp_halted) begin
      chk("halt_hlt", hlt, 1'b1);
      chk("halt_req", mem_req, 1'b0);
      chk("halt_valid", inst_valid, 1'b0);
    end else begin
      chk("hlt_low", hlt, 1'b0);
      if (busy) begin
        chk("req_hold", mem_req, 1'b1);
        chk("addr_hold", mem_addr, req_addr);
      end else if (mem_req) begin
        chk("req_addr", mem_addr, exp_req_pc);
        req_addr   = exp_req_pc;
        exp_req_pc = exp_req_pc + 16'd2;
        busy       = 1'b1;
        cnt        = (lat_fixed > 0) ? lat_fixed - 1 : int'($urandom_range(0, 3));
      end
    end
    if (busy && cnt == 0) begin
      mem_valid = 1'b1;
      mem_data  = mem_word(req_addr);
    end
  endtask

  // Drive decode-side inputs for this cycle and update the model.
  task automatic apply(input bit rdy, input bit rd, input logic [15:0] tgt, input bit hl);
    logic [15:0] pcs_exp;
    inst_ready  = rdy;
    redirect    = rd;
    redirect_pc = tgt;
    halt        = hl;
    if (!exp_halted) begin
      if (rd) begin
        exp_pc       = tgt & 16'hFFFE;
        exp_req_pc   = exp_pc;
        expect_empty = 1'b1;
      end else if (inst_valid && rdy) begin
        pcs_exp = exp_pc + 16'd2;
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst", inst, mem_word(exp_pc));
        chk("inst_pcs", inst_pcs, pcs_exp);
        exp_pc = exp_pc + 16'd2;
        if (hl) begin
          exp_halted   = 1'b1;
          expect_empty = 1'b1;
        end
      end
    end
    if (mem_valid) busy = 1'b0;
    else if (busy) cnt--;
  endtask

  task automatic reset_model();
    inst_ready   = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    halt         = 1'b0;
    mem_valid    = 1'b0;
    busy         = 1'b0;
    exp_halted   = 1'b0;
    expect_empty = 1'b0;
    exp_pc       = 16'h0000;
    exp_req_pc   = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 16'h0000);
    chk({tag, "_inst_valid"}, inst_valid, 1'b0);
    chk({tag, "_inst"}, inst, 16'h0000);
    chk({tag, "_inst_pc"}, inst_pc, 16'h0000);
    chk({tag, "_inst_pcs"}, inst_pcs, 16'h0000);
    chk({tag, "_hlt"}, hlt, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit found;
    logic [15:0] tgt;

    // Reset values
    reset_model();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_state", dbg_state, S_IDLE);
    rst_n = 1'b1;

    // Latency 3, decoder always ready
    lat_fixed = 3;
    sample();
    chk("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, 16'h0000);
    chk("lat_valid_c1", inst_valid, 1'b0);
    apply(1, 0, '0, 0);
    for (int c = 2; c <= 3; c++) begin
      sample();
      chk("lat_valid_low", inst_valid, 1'b0);
      apply(1, 0, '0, 0);
    end
    sample();
    chk("lat_valid_rise", inst_valid, 1'b1);
    chk("lat_pc", inst_pc, 16'h0000);
    chk("lat_pcs", inst_pcs, 16'h0002);
    apply(1, 0, '0, 0);

    // Redirect to 0041 while the read of 0004 is outstanding
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      sample();
      if (mem_req && mem_addr == 16'h0004 && !mem_valid) begin
        found = 1'b1;
        apply(1, 1, 16'h0041, 0);
      end else begin
        apply(1, 0, '0, 0);
      end
    end
    chk("redir_req4_seen", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      sample();
      if (inst_valid) begin
        found = 1'b1;
        chk("redir_first_pc", inst_pc, 16'h0040);
      end
      apply(1, 0, '0, 0);
    end
    chk("redir_inst_seen", found, 1'b1);

    // Backpressure: two words buffered, no request while full
    repeat (12) begin
      sample();
      apply(0, 0, '0, 0);
    end
    sample();
    chk("bp_req_idle", mem_req, 1'b0);
    chk("bp_valid", inst_valid, 1'b1);
    apply(0, 0, '0, 0);
    exp_q.push_back(16'h0042);
    exp_q.push_back(16'h0044);
    while (exp_q.size() > 0) begin
      sample();
      chk("bp_drain_valid", inst_valid, 1'b1);
      chk("bp_drain_pc", inst_pc, exp_q.pop_front());
      apply(1, 0, '0, 0);
    end

    // Redirect in the same cycle as mem_valid and a handshake
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      sample();
      if (mem_valid && inst_valid) begin
        found = 1'b1;
        apply(1, 1, 16'h0100, 0);
      end else begin
        apply(0, 0, '0, 0);
      end
    end
    chk("rv_found", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      sample();
      if (mem_req) begin
        found = 1'b1;
        chk("rv_next_addr", mem_addr, 16'h0100);
      end
      apply(1, 0, '0, 0);
    end
    chk("rv_req_seen", found, 1'b1);

    // HLT at 0006
    sample();
    apply(1, 1, 16'h0000, 0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      sample();
      if (inst_valid && inst_pc == 16'h0006) begin
        found = 1'b1;
        apply(0, 0, '0, 1);          // halt without handshake: ignored
      end else begin
        apply(1, 0, '0, 0);
      end
    end
    chk("hlt_pc_seen", found, 1'b1);
    sample();
    chk("hlt_ignored_valid", inst_valid, 1'b1);
    chk("hlt_ignored_pc", inst_pc, 16'h0006);
    apply(1, 0, '0, 1);              // accepted HLT
    sample();
    chk("hlt_state", dbg_state, S_HALTED);
    mem_valid = 1'b1;                // late, unrequested return
    mem_data  = 16'hDEAD;
    apply(1, 1, 16'h0200, 0);        // redirect after halt does nothing
    repeat (8) begin
      sample();
      apply(1, 0, '0, 0);
    end

    // Reset, then wrap at FFFE
    reset_model();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset2");
    rst_n = 1'b1;
    lat_fixed = 2;
    sample();
    apply(1, 1, 16'hFFFF, 0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      sample();
      if (inst_valid) begin
        found = 1'b1;
        chk("wrap_pc", inst_pc, 16'hFFFE);
        chk("wrap_pcs", inst_pcs, 16'h0000);
      end
      apply(1, 0, '0, 0);
    end
    chk("wrap_seen", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      sample();
      if (inst_valid && inst_pc == 16'h0000) found = 1'b1;
      apply(1, 0, '0, 0);
    end
    chk("wrap_next_seen", found, 1'b1);

    // Reset in the middle of a read
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      sample();
      if (mem_req && !mem_valid) found = 1'b1;
      else apply(1, 0, '0, 0);
    end
    chk("midwait_seen", found, 1'b1);
    reset_model();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midwait");
    @(negedge clk);
    mem_valid = 1'b1;                // stale return during reset
    mem_data  = 16'hBEEF;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("midwait_valid_after", inst_valid, 1'b0);
    rst_n = 1'b1;

    // Random traffic
    lat_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      sample();
      tgt = ($urandom_range(0, 7) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                        : 16'($urandom);
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, tgt, 0);
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
